seq_addsub: RTL and testbench
=============================

SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request to begin an operation; sampled at the rising edge.
REQ-004 SHALL have port mode, input, 1 bit: 0 selects x+y; 1 selects x-y (two's complement); sampled with start.
REQ-005 SHALL have ports x and y, input, 4 bits each: unsigned/two's-complement operands; sampled with start.
REQ-006 SHALL have port s, output, 4 bits: registered result.
REQ-007 SHALL have port c_out, output, 1 bit: registered carry out; in subtract mode, 1 means no borrow (x>=y unsigned).
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse when s and c_out are updated.
REQ-010 SHALL have port ovf, output, 1 bit, present only under OVF_DETECT_EN: signed overflow of the last result.

Function
REQ-011 SHALL implement a bit-serial adder-subtractor using one full-adder cell and a carry flip-flop, processing LSB first at one bit per clock.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; RUN has a 2-bit bit counter (0..3).
REQ-013 IDLE: start=1 at an edge -> load x into the A shift register, y XOR {4{mode}} into the B shift register, mode into the carry flip-flop, clear the counter -> RUN; start=0 -> remain in IDLE.
REQ-014 RUN: each edge computes sum bit = A[0]^B[0]^carry, shifts it into the result shift register from the MSB side, shifts A and B right, updates carry, and increments the counter.
REQ-015 RUN with counter=3: SHALL copy the completed result into s, the final carry into c_out (and ovf) -> DONE.
REQ-016 DONE: done=1 for exactly that cycle; start=1 -> accepted as in IDLE (-> RUN); else -> IDLE.
REQ-017 Latency: with start accepted at edge N, s, c_out and done SHALL be valid in the cycle after edge N+4; back-to-back throughput is one result per 5 cycles.
REQ-018 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-019 start, mode, x and y SHALL be ignored while busy=1; an operation in progress SHALL NOT be disturbed.
REQ-020 s, c_out and ovf SHALL hold their last value until the next DONE entry; intermediate bits SHALL NOT appear on s.
REQ-021 Result width SHALL be 4 bits; s = (x + (mode ? ~y+1 : y)) mod 16.

Reset
REQ-022 rst_n=0 at an edge SHALL force state IDLE, clear the counter and all shift registers, and set carry=0, s=0, c_out=0, busy=0, done=0, ovf=0.
REQ-023 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the next start after release SHALL behave as from power-up.
REQ-024 start SHALL be ignored in any cycle where rst_n=0.

Configuration
REQ-025 Macro OVF_DETECT_EN defined: the ovf port exists; it SHALL be set at DONE entry to (carry into bit 3) XOR (carry out of bit 3), captured on the final RUN edge.
REQ-026 OVF_DETECT_EN undefined: the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset, then start with mode=0, x=0101, y=0011 -> done after 4 edges; s=1000, c_out=0, ovf=1.
REQ-028 mode=1, x=0111, y=0010 -> s=0101, c_out=1, ovf=0; mode=1, x=0010, y=0111 -> s=1011, c_out=0, ovf=0.
REQ-029 mode=0, x=1111, y=0001 -> s=0000, c_out=1, ovf=0; busy=1 for exactly 4 cycles, done pulse exactly 1 cycle.
REQ-030 Pulse start again mid-RUN with different operands -> ignored; first result unchanged; start held high through DONE -> second operation begins immediately.
REQ-031 Assert rst_n=0 at RUN counter=2 -> no done pulse; all outputs 0; subsequent operation x=0001, y=0001, mode=0 -> s=0010.

Source files
------------

// File: rtl/seq_addsub.sv
// Bit-serial 4-bit adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Optional signed-overflow output is built only when OVF_DETECT_EN is defined.
module seq_addsub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       c_out,
  output logic       busy,
  output logic       done
`ifdef OVF_DETECT_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] r_q, r_d;
  logic [3:0] s_q, s_d;
  logic [1:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic       c_out_q, c_out_d;
  logic       sum_bit;
  logic       carry_nxt;
  logic       load;
  logic       last_bit;
`ifdef OVF_DETECT_EN
  logic       ovf_q, ovf_d;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 2'd3) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // The single full-adder cell shared by all four bit positions.
  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign load      = (state_q != RUN) && start;
  assign last_bit  = (state_q == RUN) && (cnt_q == 2'd3);

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
`ifdef OVF_DETECT_EN
    ovf_d   = ovf_q;
`endif
    if (load) begin
      // Subtraction is x + ~y + 1: invert B and seed the carry with mode.
      a_d     = x;
      b_d     = y ^ {4{mode}};
      carry_d = mode;
      cnt_d   = 2'd0;
    end else if (state_q == RUN) begin
      a_d     = {1'b0, a_q[3:1]};
      b_d     = {1'b0, b_q[3:1]};
      r_d     = {sum_bit, r_q[3:1]};
      carry_d = carry_nxt;
      cnt_d   = cnt_q + 2'd1;
      if (last_bit) begin
        s_d     = {sum_bit, r_q[3:1]};
        c_out_d = carry_nxt;
`ifdef OVF_DETECT_EN
        ovf_d   = carry_q ^ carry_nxt;
`endif
      end
    end
  end

  // NOTE: every register, including the shift registers, is reset so an aborted
  // operation leaves no residue for the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
`ifdef OVF_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;
`ifdef OVF_DETECT_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_seq_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [3:0] x, y;
  logic [3:0] s;
  logic       c_out, busy, done;
`ifdef OVF_DETECT_EN
  logic       ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_s;
  logic       exp_c, exp_v;

  seq_addsub dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .x     (x),
    .y     (y),
    .s     (s),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
`ifdef OVF_DETECT_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic model(input logic m, input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] rs, output logic rc, output logic rv);
    int sum;
    if (m) begin
      sum = int'(a) + ((16 - int'(b)) % 16);
      rc  = (a >= b);
      rs  = sum[3:0];
      rv  = (a[3] != b[3]) && (rs[3] != a[3]);
    end else begin
      sum = int'(a) + int'(b);
      rc  = (sum > 15);
      rs  = sum[3:0];
      rv  = (a[3] == b[3]) && (rs[3] != a[3]);
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, ".s"}, 32'(s), 32'(exp_s));
    check({tag, ".c_out"}, 32'(c_out), 32'(exp_c));
`ifdef OVF_DETECT_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_v));
`endif
  endtask

  // Called on the negedge after the start edge; waits for done with a bound,
  // counting busy cycles and verifying s does not change while running.
  task automatic wait_done(input string tag, input logic [3:0] s_prev, output int busy_cnt);
    bit seen = 0;
    busy_cnt = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_cnt++;
        if (s !== s_prev) check({tag, ".s_hold"}, 32'(s), 32'(s_prev));
        @(negedge clk);
      end
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [3:0] a, input logic [3:0] b);
    int bc;
    logic [3:0] s_prev;
    s_prev = s;
    start = 1'b1; mode = m; x = a; y = b;
    @(negedge clk);
    start = 1'b0; mode = $urandom_range(1); x = 4'($urandom); y = 4'($urandom);
    model(m, a, b, exp_s, exp_c, exp_v);
    wait_done(tag, s_prev, bc);
    check({tag, ".busy_cycles"}, 32'(bc), 32'd4);
    check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    check_result(tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check_result({tag, ".hold"});
  endtask

  initial begin
    int bc;
    logic [3:0] keep_s;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check("rst.s", 32'(s), 32'd0);
    check("rst.c_out", 32'(c_out), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_5_3",   1'b0, 4'b0101, 4'b0011);
    run_op("sub_7_2",   1'b1, 4'b0111, 4'b0010);
    run_op("sub_2_7",   1'b1, 4'b0010, 4'b0111);
    run_op("add_f_1",   1'b0, 4'b1111, 4'b0001);
    run_op("sub_0_0",   1'b1, 4'b0000, 4'b0000);
    run_op("sub_8_1",   1'b1, 4'b1000, 4'b0001);

    // Start pulsed mid-run must be ignored; start held through DONE chains a new op.
    start = 1'b1; mode = 1'b0; x = 4'd3; y = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; x = 4'd9; y = 4'd2;
    @(negedge clk);
    start = 1'b0;
    model(1'b0, 4'd3, 4'd4, exp_s, exp_c, exp_v);
    keep_s = s;
    wait_done("midrun", keep_s, bc);
    check("midrun.busy_cycles", 32'(bc), 32'd2);
    check_result("midrun");
    start = 1'b1; mode = 1'b1; x = 4'd1; y = 4'd6;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    check_result("b2b.hold_first");
    model(1'b1, 4'd1, 4'd6, exp_s, exp_c, exp_v);
    keep_s = s;
    wait_done("b2b", keep_s, bc);
    check("b2b.busy_cycles", 32'(bc), 32'd4);
    check_result("b2b");
    @(negedge clk);

    // Reset in RUN at counter 2 aborts with no done pulse; start ignored during reset.
    start = 1'b1; mode = 1'b0; x = 4'd7; y = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("abort.done", 32'(done), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.s", 32'(s), 32'd0);
    check("abort.c_out", 32'(c_out), 32'd0);
`ifdef OVF_DETECT_EN
    check("abort.ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    check("abort.start_ignored", 32'(busy), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("abort.no_done", 32'(done), 32'd0);
    run_op("post_rst", 1'b0, 4'b0001, 4'b0001);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      run_op($sformatf("rand%0d", i), 1'($urandom_range(1)), 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
